// File: rtl/tt_harness_pkg.sv
// ============================================================================
// Module   : tt_harness_pkg
// Purpose  : Shared types and constants for the TinyTapeout loopback checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tt_harness_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic        PAT_COUNT  = 1'b0;
    localparam logic        PAT_LFSR   = 1'b1;
    localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

    localparam logic [31:0] TAPS_W8    = 32'h0000_00B8;
    localparam logic [31:0] TAPS_W16   = 32'h0000_B400;

    // Known-good maximal-length tap masks; other widths fall back to the 8-bit mask.
    function automatic logic [31:0] default_taps(input int width);
        if (width == 16) begin
            return TAPS_W16;
        end
        return TAPS_W8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tt_loopback_checker_if.sv
// ============================================================================
// Module   : tt_loopback_checker_if
// Purpose  : Stimulus/response bus between the checker and the design under
//            test; uio lanes exist only with LOOPBACK_CHECKER_UIO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tt_loopback_checker_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] stim;
    logic [DATA_W-1:0] resp;
`ifdef LOOPBACK_CHECKER_UIO_EN
    logic [7:0]        uio_stim;
    logic [7:0]        uio_resp;
    logic [7:0]        uio_oe_resp;
`endif

    modport master (
        output stim,
        input  resp
`ifdef LOOPBACK_CHECKER_UIO_EN
        ,
        output uio_stim,
        input  uio_resp,
        input  uio_oe_resp
`endif
    );

    modport slave (
        input  stim,
        output resp
`ifdef LOOPBACK_CHECKER_UIO_EN
        ,
        input  uio_stim,
        output uio_resp,
        output uio_oe_resp
`endif
    );

endinterface

`default_nettype wire

// File: rtl/tt_pattern_gen.sv
// ============================================================================
// Module   : tt_pattern_gen
// Purpose  : Stimulus pattern source: seed load, counter or Fibonacci LFSR step.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tt_pattern_gen
    import tt_harness_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(TAPS_W8)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load_i,
    input  wire logic              step_i,
    input  wire logic              mode_i,
    input  wire logic [DATA_W-1:0] seed_i,
    output logic      [DATA_W-1:0] value_o
);

    logic              mode_q;
    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] value_d;
    logic [DATA_W-1:0] w_lfsr_next;
    logic [DATA_W-1:0] w_load_val;

    generate
        if (DATA_W == 1) begin : g_lfsr_w1
            assign w_lfsr_next = ^(value_q & LFSR_TAPS);
        end else begin : g_lfsr_wn
            assign w_lfsr_next = {value_q[DATA_W-2:0], ^(value_q & LFSR_TAPS)};
        end
    endgenerate

    // An all-zero LFSR state would never leave zero, so it is replaced by 1.
    assign w_load_val = ((mode_i == PAT_LFSR) && (seed_i == '0)) ? DATA_W'(1) : seed_i;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = w_load_val;
        end else if (step_i) begin
            value_d = (mode_q == PAT_LFSR) ? w_lfsr_next : value_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            mode_q  <= PAT_COUNT;
        end else begin
            value_q <= value_d;
            if (load_i) begin
                mode_q <= mode_i;
            end
        end
    end

    assign value_o = value_q;

endmodule

`default_nettype wire

// File: rtl/tt_loopback_checker.sv
// ============================================================================
// Module   : tt_loopback_checker
// Purpose  : Drives a pattern into a DUT and checks its delayed response,
//            counting mismatches; optional uio path via LOOPBACK_CHECKER_UIO_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tt_loopback_checker
    import tt_harness_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                LATENCY   = 2,
    parameter int                NUM_VEC   = 256,
    parameter int                ERR_W     = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(default_taps(DATA_W))
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              abort,
    input  wire logic              mode,
    input  wire logic [DATA_W-1:0] seed,
    input  wire logic [DATA_W-1:0] resp_mask,
    tt_loopback_checker_if.master  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic      [ERR_W-1:0]  err_cnt,
    output logic      [15:0]       first_err_idx
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] exp;
        logic [15:0]       idx;
    } pipe_ent_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       vec_idx_q;
    logic [3:0]        drain_cnt_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [ERR_W-1:0]  err_cnt_d;
    logic [15:0]       first_err_q;
    logic [15:0]       first_err_d;

    logic [DATA_W-1:0] w_stim;
    logic              w_start_ok;
    logic              w_last;
    logic              w_step;
    logic              w_mis_main;
    logic              w_mis_uio;
    logic              w_mismatch;
    pipe_ent_t         w_issue_ent;
    pipe_ent_t         w_cmp_ent;

    assign w_start_ok = start && !abort && ((state_q == IDLE) || (state_q == DONE));
    assign w_last     = (vec_idx_q == 16'(NUM_VEC - 1));
    assign w_step     = !abort && (state_q == RUN) && !w_last;

    tt_pattern_gen #(
        .DATA_W    (DATA_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_pattern_gen (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_start_ok),
        .step_i  (w_step),
        .mode_i  (mode),
        .seed_i  (seed),
        .value_o (w_stim)
    );

    assign bus.stim = w_stim;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_idx_q   <= '0;
            drain_cnt_q <= '0;
        end else if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        vec_idx_q <= '0;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        if (LATENCY == 0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end else begin
                        vec_idx_q <= vec_idx_q + 16'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == 4'(LATENCY - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Expected values travel alongside the DUT's latency instead of being regenerated.
    assign w_issue_ent = {(state_q == RUN), w_stim, vec_idx_q};

    generate
        if (LATENCY == 0) begin : g_lat0
            assign w_cmp_ent = w_issue_ent;
        end else begin : g_pipe
            pipe_ent_t pipe_q [LATENCY];

            always_ff @(posedge clk) begin
                if (rst || abort) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= w_issue_ent;
                    for (int i = 1; i < LATENCY; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign w_cmp_ent = pipe_q[LATENCY-1];
        end
    endgenerate

    assign w_mis_main = |((bus.resp ^ w_cmp_ent.exp) & resp_mask);

`ifdef LOOPBACK_CHECKER_UIO_EN
    logic [7:0] w_stim_lo8;
    logic [7:0] w_exp_lo8;

    assign w_stim_lo8    = 8'(w_stim);
    assign w_exp_lo8     = 8'(w_cmp_ent.exp);
    assign bus.uio_stim  = ~w_stim_lo8;
    assign w_mis_uio     = |((bus.uio_resp ^ ~w_exp_lo8) & bus.uio_oe_resp);
`else
    assign w_mis_uio     = 1'b0;
`endif

    assign w_mismatch = w_cmp_ent.valid && (w_mis_main || w_mis_uio);

    always_comb begin
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (w_start_ok) begin
            err_cnt_d   = '0;
            first_err_d = NO_ERR_IDX;
        end else if (w_mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (first_err_q == NO_ERR_IDX) begin
                first_err_d = w_cmp_ent.idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q   <= '0;
            first_err_q <= NO_ERR_IDX;
        end else begin
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q && (err_cnt_q == '0);
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_loopback_checker.sv
// ============================================================================
// Module   : tb_tt_loopback_checker
// Purpose  : Self-checking bench for tt_loopback_checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tt_loopback_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A: 8-bit, latency 2, 16 vectors ----------------
    logic        a_start = 0, a_abort = 0, a_mode = 0;
    logic [7:0]  a_seed = 0, a_mask = 8'hFF, a_fval = 0, a_fbits = 0;
    logic        a_busy, a_done, a_pass;
    logic [7:0]  a_err;
    logic [15:0] a_first;
    logic [7:0]  a_d1, a_d2;
    tt_loopback_checker_if #(.DATA_W(8)) a_bus ();

    // DUT stand-in: two-cycle delay that corrupts the vector whose value is a_fval.
    always @(posedge clk) begin
        a_d1 <= a_bus.stim ^ ((a_bus.stim == a_fval) ? a_fbits : 8'h00);
        a_d2 <= a_d1;
    end
    assign a_bus.resp = a_d2;

    tt_loopback_checker #(.DATA_W(8), .LATENCY(2), .NUM_VEC(16), .ERR_W(8), .LFSR_TAPS(8'hB8)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .mode(a_mode), .seed(a_seed),
        .resp_mask(a_mask), .bus(a_bus), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_cnt(a_err), .first_err_idx(a_first));

    // ---------------- instances B/C/D share their run controls ----------------
    logic        s_start = 0, s_mode = 1, s_abort = 0;
    logic [7:0]  s_seed = 0, s_mask = 8'hFF, b_flip = 0;
    logic        b_busy, b_done, b_pass, c_busy, c_done, c_pass, d_busy, d_done, d_pass;
    logic [7:0]  b_err, d_err;
    logic [3:0]  c_err;
    logic [15:0] b_first, c_first, d_first;
    logic [7:0]  d_d1, d_d2;
    tt_loopback_checker_if #(.DATA_W(8)) b_bus ();
    tt_loopback_checker_if #(.DATA_W(8)) c_bus ();
    tt_loopback_checker_if #(.DATA_W(8)) d_bus ();

    assign b_bus.resp = b_bus.stim ^ b_flip;
    assign c_bus.resp = 8'hFF;
    always @(posedge clk) begin
        d_d1 <= d_bus.stim;
        d_d2 <= d_d1;
    end
    assign d_bus.resp = d_d2;

`ifdef LOOPBACK_CHECKER_UIO_EN
    assign a_bus.uio_resp = 8'h00; assign a_bus.uio_oe_resp = 8'h00;
    assign b_bus.uio_resp = 8'h00; assign b_bus.uio_oe_resp = 8'h00;
    assign c_bus.uio_resp = 8'h00; assign c_bus.uio_oe_resp = 8'h00;
    assign d_bus.uio_resp = 8'h00; assign d_bus.uio_oe_resp = 8'h00;
`endif

    tt_loopback_checker #(.DATA_W(8), .LATENCY(0), .NUM_VEC(1), .ERR_W(8), .LFSR_TAPS(8'hB8)) u_b (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .mode(s_mode), .seed(s_seed),
        .resp_mask(s_mask), .bus(b_bus), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_cnt(b_err), .first_err_idx(b_first));

    tt_loopback_checker #(.DATA_W(8), .LATENCY(2), .NUM_VEC(40), .ERR_W(4), .LFSR_TAPS(8'hB8)) u_c (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .mode(s_mode), .seed(s_seed),
        .resp_mask(s_mask), .bus(c_bus), .busy(c_busy), .done(c_done), .pass(c_pass),
        .err_cnt(c_err), .first_err_idx(c_first));

    tt_loopback_checker #(.DATA_W(8), .LATENCY(2), .NUM_VEC(300), .ERR_W(8), .LFSR_TAPS(8'hB8)) u_d (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .mode(s_mode), .seed(s_seed),
        .resp_mask(s_mask), .bus(d_bus), .busy(d_busy), .done(d_done), .pass(d_pass),
        .err_cnt(d_err), .first_err_idx(d_first));

    // ---------------- reference model and helpers ----------------
    logic [7:0] m_seq [300];
    logic [7:0] a_got [16];
    logic [7:0] d_got [300];

    function automatic logic [7:0] ref_next(input logic m, input logic [7:0] v);
        if (!m) return v + 8'd1;
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic model_seq(input logic m, input logic [7:0] sd, input int cnt);
        logic [7:0] v;
        v = (m && sd == 8'h00) ? 8'h01 : sd;
        for (int k = 0; k < cnt; k++) begin
            m_seq[k] = v;
            v = ref_next(m, v);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_a(input logic m, input logic [7:0] sd, mk, fv, fb, output int n);
        a_mode = m; a_seed = sd; a_mask = mk; a_fval = fv; a_fbits = fb;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_got[0] = a_bus.stim;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n < 16) a_got[n] = a_bus.stim;
        end while (!a_done && n < 200);
    endtask

    task automatic check_a(input string tag, input int n, input logic m, input logic [7:0] sd,
                           input int e_err, input int e_first, input logic e_pass);
        chk({tag, "_cycles"}, n, 18);
        chk({tag, "_done"}, a_done, 1);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_err"}, a_err, e_err);
        chk({tag, "_first"}, a_first, e_first);
        chk({tag, "_pass"}, a_pass, e_pass);
        model_seq(m, sd, 16);
        for (int k = 0; k < 16; k++) chk({tag, "_stim"}, a_got[k], m_seq[k]);
    endtask

    typedef struct {
        logic       mode;
        logic [7:0] seed, mask, fval, fbits;
        int         err;
        int         first;
        logic       pass;
    } vec_t;

    vec_t tab [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e_err, e_first, b_when, c_when, d_when;
        logic m;
        logic [7:0] sd, mk, fv, fb;

        tab[0] = '{1'b0, 8'h00, 8'hFF, 8'h05, 8'h00, 0, 'hFFFF, 1'b1};
        tab[1] = '{1'b0, 8'h00, 8'hFF, 8'h05, 8'h08, 1, 5,      1'b0};
        tab[2] = '{1'b0, 8'h00, 8'hF7, 8'h05, 8'h08, 0, 'hFFFF, 1'b1};
        tab[3] = '{1'b1, 8'h00, 8'hFF, 8'h01, 8'h01, 1, 0,      1'b0};
        tab[4] = '{1'b0, 8'hF8, 8'h00, 8'hFB, 8'hFF, 0, 'hFFFF, 1'b1};
        tab[5] = '{1'b0, 8'hF8, 8'hFF, 8'h07, 8'h80, 1, 15,     1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stim", a_bus.stim, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_err", a_err, 0);
        chk("rst_first", a_first, 16'hFFFF);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_a(tab[i].mode, tab[i].seed, tab[i].mask, tab[i].fval, tab[i].fbits, n);
            check_a("table", n, tab[i].mode, tab[i].seed, tab[i].err, tab[i].first, tab[i].pass);
        end

        for (int r = 0; r < 20; r++) begin
            m  = 1'($urandom_range(0, 1));
            sd = 8'($urandom);
            mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            fb = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            model_seq(m, sd, 16);
            fv = ($urandom_range(0, 3) != 0) ? m_seq[$urandom_range(0, 15)] : 8'($urandom);
            e_err = 0;
            e_first = 'hFFFF;
            for (int k = 0; k < 16; k++) begin
                if (m_seq[k] == fv && (fb & mk) != 8'h00) begin
                    if (e_first == 'hFFFF) e_first = k;
                    if (e_err < 255) e_err++;
                end
            end
            run_a(m, sd, mk, fv, fb, n);
            check_a("rand", n, m, sd, e_err, e_first, e_err == 0);
        end

        // start during RUN must not restart the run
        a_mode = 0; a_seed = 8'h00; a_mask = 8'hFF; a_fbits = 8'h00;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 4;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!a_done && n < 200);
        chk("restart_ignored_cycles", n, 18);
        chk("restart_ignored_pass", a_pass, 1);

        // abort at vector 7
        a_seed = 8'h10;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_vec7_stim", a_bus.stim, 8'h17);
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_stim_hold", a_bus.stim, 8'h17);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_idle_done", a_done, 0);
        run_a(0, 8'h10, 8'hFF, 8'h80, 8'h00, n);
        check_a("after_abort", n, 0, 8'h10, 0, 'hFFFF, 1);

        // abort and start together from DONE: abort wins
        a_abort = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0; a_start = 1'b0;
        chk("abort_start_busy", a_busy, 0);
        chk("abort_start_done", a_done, 0);

        // reset during DRAIN
        a_seed = 8'h00; a_fval = 8'h05; a_fbits = 8'h08;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("drain_busy", a_busy, 1);
        chk("drain_err", a_err, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_drain_stim", a_bus.stim, 0);
        chk("rst_drain_busy", a_busy, 0);
        chk("rst_drain_done", a_done, 0);
        chk("rst_drain_pass", a_pass, 0);
        chk("rst_drain_err", a_err, 0);
        chk("rst_drain_first", a_first, 16'hFFFF);

        // B: latency 0; C: 4-bit saturation; D: LFSR full period
        s_mode = 1'b1; s_seed = 8'h00; b_flip = 8'h00;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        b_when = -1; c_when = -1; d_when = -1;
        n = 0;
        d_got[0] = d_bus.stim;
        chk("lat0_busy", b_busy, 1);
        do begin
            @(posedge clk); #1;
            n++;
            if (n < 300) d_got[n] = d_bus.stim;
            if (b_done && b_when < 0) b_when = n;
            if (c_done && c_when < 0) c_when = n;
            if (d_done && d_when < 0) d_when = n;
        end while (d_when < 0 && n < 400);
        chk("lat0_cycles", b_when, 1);
        chk("lat0_pass", b_pass, 1);
        chk("lat0_err", b_err, 0);
        chk("sat_cycles", c_when, 42);
        chk("sat_err", c_err, 15);
        chk("sat_first", c_first, 0);
        chk("sat_pass", c_pass, 0);
        chk("lfsr_cycles", d_when, 302);
        chk("lfsr_vec0", d_got[0], 8'h01);
        chk("lfsr_vec1", d_got[1], 8'h02);
        chk("lfsr_vec255", d_got[255], 8'h01);
        chk("lfsr_pass", d_pass, 1);
        model_seq(1'b1, 8'h00, 300);
        for (int k = 0; k < 300; k++) chk("lfsr_seq", d_got[k], m_seq[k]);

        b_flip = 8'h04;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(posedge clk); #1;
        chk("lat0_fault_done", b_done, 1);
        chk("lat0_fault_err", b_err, 1);
        chk("lat0_fault_first", b_first, 0);
        chk("lat0_fault_pass", b_pass, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
